// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the IF/ID1/regfile/ALU/dmem datapath.
// Optional CTRL_STEP_EN adds a single-step input that gates each instruction.
module mc_ctrl_fsm #(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CTRL_STEP_EN
  input  logic       step,
`endif
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       ZF,
  output logic       PC_Write,
  output logic       PC0_Write,
  output logic       IR_Write,
  output logic       Reg_Write,
  output logic       Mem_Write,
  output logic [3:0] ALU_OP,
  output logic       rs2_imm_s,
  output logic [1:0] w_data_s,
  output logic [1:0] pc_s,
  output logic [3:0] state,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,  S_IF   = 4'd1,  S_ID   = 4'd2,
    S_EXR  = 4'd3,  S_EXI  = 4'd4,  S_WB   = 4'd5,
    S_ADDR = 4'd6,  S_MEMR = 4'd7,  S_LDWB = 4'd8,
    S_MEMW = 4'd9,  S_LUI  = 4'd10, S_BR   = 4'd11,
    S_JAL  = 4'd12, S_JALR = 4'd13, S_ERR  = 4'd15
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef CTRL_STEP_EN
  localparam state_t S_DONE = S_IDLE;
`else
  localparam state_t S_DONE = S_IF;
`endif

  state_t     st, nx, dec;
  logic       jalr_q, store_q;
  logic [3:0] alu_q, alu_d;
  logic       bad, br_taken;

  always_comb begin
    bad = 1'b0;
    case (opcode)
      OP_R: bad = !(funct7 == 7'd0 || funct7 == F7_ALT) ||
                  (funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101);
      OP_I: bad = funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101;
      OP_LD, OP_ST: bad = funct3 != 3'b010;
      OP_BR: bad = funct3 != 3'b000 && funct3 != 3'b001;
      default: bad = 1'b0;
    endcase
  end

  always_comb begin
    dec = S_ERR;
    unique case (1'b1)
      opcode == OP_R:    dec = S_EXR;
      opcode == OP_I:    dec = S_EXI;
      opcode == OP_LD:   dec = S_ADDR;
      opcode == OP_ST:   dec = S_ADDR;
      opcode == OP_LUI:  dec = S_LUI;
      opcode == OP_BR:   dec = S_BR;
      opcode == OP_JAL:  dec = S_JAL;
      opcode == OP_JALR: dec = S_EXI;
      default:           dec = S_ERR;
    endcase
    if (STRICT_DECODE && bad)
      dec = S_ERR;
  end

  // ALU function is latched at decode so S_WB can hold it
  always_comb begin
    alu_d = {1'b0, funct3};
    if (opcode == OP_R)
      alu_d = {funct7[5], funct3};
    else if (opcode == OP_JALR)
      alu_d = 4'b0000;
    else if (funct3 == 3'b101)
      alu_d = {funct7[5], 3'b101};
  end

  always_comb begin
    nx = st;
    case (st)
      S_IDLE: begin
`ifdef CTRL_STEP_EN
        nx = step ? S_IF : S_IDLE;
`else
        nx = S_IF;
`endif
      end
      S_IF:   nx = S_ID;
      S_ID:   nx = dec;
      S_EXR:  nx = S_WB;
      S_EXI:  nx = jalr_q ? S_JALR : S_WB;
      S_ADDR: nx = store_q ? S_MEMW : S_MEMR;
      S_MEMR: nx = S_LDWB;
      S_ERR:  nx = S_ERR;
      S_WB, S_LDWB, S_MEMW, S_LUI,
      S_BR, S_JAL, S_JALR: nx = S_DONE;
      default: nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_IDLE;
      jalr_q  <= 1'b0;
      store_q <= 1'b0;
      alu_q   <= 4'd0;
    end else begin
      st <= nx;
      if (st == S_IF) begin
        jalr_q  <= 1'b0;
        store_q <= 1'b0;
      end else if (st == S_ID) begin
        jalr_q  <= opcode == OP_JALR;
        store_q <= opcode == OP_ST;
        alu_q   <= alu_d;
      end
    end
  end

  assign br_taken = (funct3 == 3'b000 && ZF) ||
                    (funct3 == 3'b001 && !ZF);
  assign state = st;

  // outputs are forced idle while rst is high so no write leaks
  always_comb begin
    PC_Write  = 1'b0;
    PC0_Write = 1'b0;
    IR_Write  = 1'b0;
    Reg_Write = 1'b0;
    Mem_Write = 1'b0;
    ALU_OP    = 4'd0;
    rs2_imm_s = 1'b0;
    w_data_s  = 2'b00;
    pc_s      = 2'b00;
    err       = 1'b0;
    if (!rst) begin
      case (st)
        S_IF: begin
          IR_Write  = 1'b1;
          PC_Write  = 1'b1;
          PC0_Write = 1'b1;
        end
        S_EXR: ALU_OP = alu_q;
        S_EXI: begin
          ALU_OP    = alu_q;
          rs2_imm_s = 1'b1;
        end
        S_WB: begin
          Reg_Write = 1'b1;
          ALU_OP    = alu_q;
        end
        S_ADDR, S_MEMR: rs2_imm_s = 1'b1;
        S_LDWB: begin
          Reg_Write = 1'b1;
          w_data_s  = 2'b01;
        end
        S_MEMW: begin
          Mem_Write = 1'b1;
          rs2_imm_s = 1'b1;
        end
        S_LUI: begin
          Reg_Write = 1'b1;
          w_data_s  = 2'b10;
        end
        S_BR: begin
          ALU_OP = 4'b1000;
          if (br_taken) begin
            PC_Write = 1'b1;
            pc_s     = 2'b01;
          end
        end
        S_JAL: begin
          Reg_Write = 1'b1;
          w_data_s  = 2'b11;
          PC_Write  = 1'b1;
          pc_s      = 2'b01;
        end
        S_JALR: begin
          Reg_Write = 1'b1;
          w_data_s  = 2'b11;
          PC_Write  = 1'b1;
          pc_s      = 2'b10;
          rs2_imm_s = 1'b1;
        end
        S_ERR: err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-instruction cycle scripts
// are queued by the driver and checked by a negedge monitor.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pc0w, irw, rw, mw;
    logic [3:0] alu;
    logic       rs2;
    logic [1:0] wds, pcs;
    logic       err;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       ZF = 1'b0;
  logic       PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write;
  logic [3:0] ALU_OP, state;
  logic       rs2_imm_s, err;
  logic [1:0] w_data_s, pc_s;

  int n_chk = 0;
  int n_fail = 0;
  rec_t exp_q[$];
  rec_t tmp_q[$];

  mc_ctrl_fsm #(.STRICT_DECODE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .ZF(ZF),
    .PC_Write(PC_Write), .PC0_Write(PC0_Write), .IR_Write(IR_Write),
    .Reg_Write(Reg_Write), .Mem_Write(Mem_Write), .ALU_OP(ALU_OP),
    .rs2_imm_s(rs2_imm_s), .w_data_s(w_data_s), .pc_s(pc_s),
    .state(state), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    rec_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{state, PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write,
            ALU_OP, rs2_imm_s, w_data_s, pc_s, err};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ctrl_out t=%0t st got %0d exp %0d vec got %h exp %h",
                 $time, a.st, e.st, a, e);
      end
    end
  end

  function automatic rec_t mk(int s);
    rec_t r = '0;
    r.st = 4'(s);
    return r;
  endfunction

  function automatic bit legal(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    bit alt_bad = (f7 == 7'h20) && !(f3 == 3'd0 || f3 == 3'd5);
    case (op)
      7'b0110011: return (f7 == 7'h00 || f7 == 7'h20) && !alt_bad;
      7'b0010011: return !alt_bad;
      7'b0000011, 7'b0100011: return f3 == 3'd2;
      7'b1100011: return f3 == 3'd0 || f3 == 3'd1;
      7'b0110111, 7'b1101111, 7'b1100111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // cycle-by-cycle expected outputs for one instruction, IF onward
  task automatic expand(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic zf);
    rec_t r, w;
    tmp_q.delete();
    r = mk(1); r.irw = 1; r.pcw = 1; r.pc0w = 1;
    tmp_q.push_back(r);
    tmp_q.push_back(mk(2));
    if (!legal(op, f3, f7)) begin
      r = mk(15); r.err = 1;
      repeat (10) tmp_q.push_back(r);
      return;
    end
    case (op)
      7'b0110011, 7'b0010011: begin
        r = mk(op == 7'b0110011 ? 3 : 4);
        r.rs2 = op == 7'b0010011;
        if (op == 7'b0110011) r.alu = {f7[5], f3};
        else if (f3 == 3'd5) r.alu = {f7[5], 3'd5};
        else r.alu = {1'b0, f3};
        w = mk(5); w.rw = 1; w.alu = r.alu;
        tmp_q.push_back(r); tmp_q.push_back(w);
      end
      7'b1100111: begin
        r = mk(4); r.rs2 = 1;
        w = mk(13); w.rw = 1; w.wds = 3; w.pcw = 1; w.pcs = 2; w.rs2 = 1;
        tmp_q.push_back(r); tmp_q.push_back(w);
      end
      7'b0000011: begin
        r = mk(6); r.rs2 = 1; tmp_q.push_back(r);
        r = mk(7); r.rs2 = 1; tmp_q.push_back(r);
        r = mk(8); r.rw = 1; r.wds = 1; tmp_q.push_back(r);
      end
      7'b0100011: begin
        r = mk(6); r.rs2 = 1; tmp_q.push_back(r);
        r = mk(9); r.rs2 = 1; r.mw = 1; tmp_q.push_back(r);
      end
      7'b0110111: begin
        r = mk(10); r.rw = 1; r.wds = 2; tmp_q.push_back(r);
      end
      7'b1100011: begin
        r = mk(11); r.alu = 4'b1000;
        if ((f3 == 3'd0 && zf) || (f3 == 3'd1 && !zf)) begin
          r.pcw = 1; r.pcs = 1;
        end
        tmp_q.push_back(r);
      end
      default: begin
        r = mk(12); r.rw = 1; r.wds = 3; r.pcw = 1; r.pcs = 1;
        tmp_q.push_back(r);
      end
    endcase
  endtask

  // enters with the DUT in a cycle whose state is cur; leaves in S_IF
  task automatic do_reset(int cur);
    rst = 1'b1;
    exp_q.push_back(mk(cur));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(mk(0));
    @(posedge clk); #1;
  endtask

  // cut > 0 asserts rst in the cycle after the first cut script entries
  task automatic run(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                     logic zf, int cut);
    int n;
    bool_ok: begin end
    expand(op, f3, f7, zf);
    n = tmp_q.size();
    if (cut <= 0 || cut >= n) cut = n;
    opcode = op; funct3 = f3; funct7 = f7; ZF = zf;
    for (int i = 0; i < cut; i++) exp_q.push_back(tmp_q[i]);
    repeat (cut) begin
      @(posedge clk); #1;
    end
    if (cut < n) do_reset(int'(tmp_q[cut].st));
    else if (!legal(op, f3, f7)) do_reset(15);
  endtask

  initial begin
    logic [6:0] ops [9];
    logic [6:0] op, f7;
    logic [2:0] f3;
    int cut;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b1111111};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run(7'b0110011, 3'b000, 7'h00, 1'b0, 0);
    run(7'b0110011, 3'b000, 7'h20, 1'b0, 0);
    run(7'b0010011, 3'b101, 7'h20, 1'b0, 0);
    run(7'b0000011, 3'b010, 7'h00, 1'b0, 0);
    run(7'b0100011, 3'b010, 7'h00, 1'b0, 0);
    run(7'b1100011, 3'b000, 7'h00, 1'b1, 0);
    run(7'b1100011, 3'b000, 7'h00, 1'b0, 0);
    run(7'b1100011, 3'b001, 7'h00, 1'b0, 0);
    run(7'b1101111, 3'b000, 7'h00, 1'b0, 0);
    run(7'b1100111, 3'b000, 7'h00, 1'b0, 0);
    run(7'b0110111, 3'b011, 7'h55, 1'b0, 0);
    run(7'b1111111, 3'b000, 7'h00, 1'b0, 0);
    run(7'b0100011, 3'b010, 7'h00, 1'b0, 3);
    run(7'b0110011, 3'b010, 7'h20, 1'b0, 0);
    run(7'b0000011, 3'b000, 7'h00, 1'b0, 0);
    run(7'b1100011, 3'b100, 7'h00, 1'b1, 0);

    for (int k = 0; k < 200; k++) begin
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      f3 = 3'($urandom);
      if (op == 7'b0010011)
        f7 = (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      else case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      if (op inside {7'b0000011, 7'b0100011} && $urandom_range(0, 2) != 0)
        f3 = 3'd2;
      if (op == 7'b1100011 && $urandom_range(0, 2) != 0)
        f3 = 3'($urandom_range(0, 1));
      if (op == 7'b0110011 && $urandom_range(0, 2) != 0)
        f7 = (f3 == 3'd0 || f3 == 3'd5) ? 7'h20 : 7'h00;
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
      run(op, f3, f7, 1'($urandom), cut);
    end

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
